// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH register file with one synchronous write port
// and two combinational read ports (rs, rt).
// ZERO_REG=1 hardwires entry 0 to zero. Addresses at or above DEPTH write
// nothing and read as zero.
// Optional build macro REGISTER_FILE_BYPASS_EN: forwards the pending write
// data to a read port that addresses the entry being written in that cycle.
module register_file #(
   parameter int              WIDTH       = 32,
   parameter int              DEPTH       = 32,
   parameter int              ADDR_W      = 5,
   parameter int              ZERO_REG    = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_enable,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [ADDR_W-1:0] rs_addr,
   output logic [WIDTH-1:0]  rs_data,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [WIDTH-1:0]  rt_data
);

   // Storage array. Entry 0 is held at zero when hardwired, and the read
   // mux never selects it in that case, so it reads 0 even before reset.
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   // Next-state for every entry: reset wins over a write. Each entry matches
   // only its own exact address, so out-of-range writes select no entry.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (ZERO_REG != 0 && i == 0) begin
            mem_d[i] = '0;
         end else if (reset) begin
            mem_d[i] = RESET_VALUE;
         end else if (wr_enable && (wr_addr == ADDR_W'(i))) begin
            mem_d[i] = wr_data;
         end
      end
   end

   // Storage update on the rising clock edge.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

`ifdef REGISTER_FILE_BYPASS_EN
   // A write is forwardable only if it will really land in storage.
   logic fwd_ok;
   always_comb begin
      fwd_ok = wr_enable && !reset && (int'(wr_addr) < DEPTH) &&
               !(ZERO_REG != 0 && wr_addr == '0);
   end
`endif

   // Combinational read ports. An unmatched address (out of range or the
   // hardwired zero entry) leaves the default of zero.
   always_comb begin
      rs_data = '0;
      rt_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!(ZERO_REG != 0 && i == 0)) begin
            if (rs_addr == ADDR_W'(i)) begin
               rs_data = mem_q[i];
            end
            if (rt_addr == ADDR_W'(i)) begin
               rt_data = mem_q[i];
            end
         end
      end
`ifdef REGISTER_FILE_BYPASS_EN
      if (fwd_ok && (wr_addr == rs_addr)) begin
         rs_data = wr_data;
      end
      if (fwd_ok && (wr_addr == rt_addr)) begin
         rt_data = wr_data;
      end
`endif
   end

endmodule
